serializer_ctrl: RTL and testbench
==================================

Name: serializer_ctrl

Overview:
Front-end controller for the move serializer.
- Arbitrates two requesters (req0 = engine, req1 = player input) with round-robin priority for the single serializer.
- Pulses the serializer load with the granted 32-bit packed move word.
- Captures each 16-bit move the serializer emits into a small FIFO.
- Hands moves downstream to the move validator over a valid/ready handshake.

Parameters:
MOVES_PER_WORD, 2, moves packed per 32-bit word; one capture per move.
FIFO_DEPTH, 4, move FIFO entries; power of two, and at least MOVES_PER_WORD.
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with SER_WATCHDOG_EN.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-high reset
req0  in  1  requester 0 has a word pending; held until gnt0
data0  in  32  requester 0 packed move word
gnt0  out  1  1-cycle acceptance pulse for requester 0
req1  in  1  requester 1 has a word pending; held until gnt1
data1  in  32  requester 1 packed move word
gnt1  out  1  1-cycle acceptance pulse for requester 1
ser_load  out  1  serializer load strobe
ser_in  out  32  word to serializer
ser_out1..ser_out4  in  4 each  serializer nibble outputs
ser_move_cnt  in  4  serializer move counter
ser_done  in  1  serializer finished current word
move_valid  out  1  FIFO head valid
move_data  out  16  {out1,out2,out3,out4} of FIFO head
move_ready  in  1  downstream accepts head
busy  out  1  state != IDLE
fifo_count  out  3  FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: capture attempted while FIFO full
timeout_err  out  1  sticky watchdog flag; present only with SER_WATCHDOG_EN

Behaviour:
- Reset (synchronous, active-high, clk rising):
  - Outputs: gnt0=gnt1=0, ser_load=0, ser_in=0, move_valid=0, move_data=0, busy=0, fifo_count=0, overflow=0, timeout_err=0.
  - Internal: FIFO flushed, rr pointer set to favour req0, state=IDLE.
  - Reset mid-WAIT abandons the word and drops captured moves.
- State IDLE:
  - Grant condition: any req AND (FIFO_DEPTH - fifo_count) >= MOVES_PER_WORD, counting a same-cycle pop.
  - Arbitration: if both request, grant the one not last granted; a single request wins outright.
  - On grant: the gnt pulse is registered (next cycle), ser_in latches the granted data, rr pointer updates, go to LOAD.
- State LOAD, exactly 1 cycle:
  - ser_load=1.
  - last_cnt <= ser_move_cnt; cap_cnt <= 0.
  - Next state WAIT.
- State WAIT:
  - ser_load=0.
  - Capture: each cycle where ser_move_cnt != last_cnt and cap_cnt < MOVES_PER_WORD, push {ser_out1..4}, set last_cnt <= ser_move_cnt, increment cap_cnt.
  - Exit: ser_done=1 AND cap_cnt == MOVES_PER_WORD (including a capture completing this cycle) goes to IDLE.
  - New grants wait until the cycle after the return to IDLE.
- FIFO:
  - Register-based, push at tail, pop when move_valid && move_ready.
  - Push and pop in the same cycle leaves fifo_count unchanged.
  - Full push: drop the move, set overflow (unreachable under the grant rule; present for checking).
  - Empty: move_valid=0; move_data holds its last value.
  - Pointers wrap modulo FIFO_DEPTH.
  - move_data is a registered head with no bypass: a capture appears as move_valid no earlier than the next cycle.
- Requester rule:
  - req drop before gnt is legal; the request is simply lost.
  - data must be stable while req is high.

Optional Feature:
SER_WATCHDOG_EN:
- Defined:
  - A counter clears on LOAD and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without the exit condition sets sticky timeout_err.
  - State forced to IDLE; already-captured moves are kept.
  - timeout_err clears only on reset.
- Undefined: no counter, no timeout_err port; WAIT persists indefinitely.

Test Plan:
1. req0=1, data0=32'h12345670, move_ready=1; serializer model emits two moves then done -> one gnt0 pulse, one ser_load pulse with ser_in=32'h12345670, move_data 16'h1234 then 16'h5670, fifo_count returns to 0, busy ends 0.
2. req0 and req1 both high continuously, data0=32'hAAAA0000, data1=32'h5555FFFF -> grants alternate gnt0,gnt1,gnt0; ser_in alternates to match; never two consecutive grants to the same requester.
3. move_ready=0, req0 issues two words -> fifo_count reaches 4, third request not granted (no gnt, ser_load=0); one pop raises space to 1 (still no grant); a second pop leaves space 2 and the grant follows.
4. Push and pop in the same cycle with fifo_count=2 -> fifo_count stays 2, order preserved (FIFO head matches the first captured move).
5. reset asserted in WAIT after one capture -> next cycle: all outputs at reset values, fifo_count=0, state IDLE; a subsequent req0 is granted normally.
6. SER_WATCHDOG_EN, TIMEOUT_CYCLES=64, serializer never asserts done -> timeout_err=1 and busy=0 after 64 WAIT cycles, captured moves retained; without the macro busy stays 1.

Source files
------------

// File: rtl/serializer_ctrl.sv
// Front-end controller for the move serializer: round-robin arbitration, load strobe,
// per-move capture into a register FIFO, and a valid/ready hand-off. Optional macro: SER_WATCHDOG_EN.
module serializer_ctrl #(
  parameter int MOVES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req0,
  input  logic [31:0]                        data0,
  output logic                               gnt0,
  input  logic                               req1,
  input  logic [31:0]                        data1,
  output logic                               gnt1,
  output logic                               ser_load,
  output logic [31:0]                        ser_in,
  input  logic [3:0]                         ser_out1,
  input  logic [3:0]                         ser_out2,
  input  logic [3:0]                         ser_out3,
  input  logic [3:0]                         ser_out4,
  input  logic [3:0]                         ser_move_cnt,
  input  logic                               ser_done,
  output logic                               move_valid,
  output logic [15:0]                        move_data,
  input  logic                               move_ready,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow
`ifdef SER_WATCHDOG_EN
  ,
  output logic                               timeout_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CAP_W = $clog2(MOVES_PER_WORD + 1);
  localparam logic [CAP_W-1:0] CAP_MAX  = CAP_W'(MOVES_PER_WORD);
  localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(MOVES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < MOVES_PER_WORD || FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("serializer_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic              gnt0_reg, gnt1_reg;
  logic [31:0]       ser_in_reg;
  logic              last_gnt_reg;   // 1: requester 1 was granted last
  logic [3:0]        last_cnt_reg;
  logic [CAP_W-1:0]  cap_cnt_reg;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [15:0]       move_data_reg, head_next;
  logic              overflow_reg;
  logic [FIFO_DEPTH-1:0] wr_en;

  logic        pop, space_ok, grant, pick1;
  logic        capture, push_ok, cap_full, wait_exit, timeout_hit;
  logic [15:0] push_data;

  // ---------------- arbitration / capture decode ----------------
  assign pop       = (count_reg != '0) && move_ready;
  // A pop this cycle frees a slot before the granted word can produce any move.
  assign space_ok  = (int'(count_reg) - int'(pop)) <= (FIFO_DEPTH - MOVES_PER_WORD);
  assign grant     = (state_reg == ST_IDLE) && (req0 || req1) && space_ok;
  assign pick1     = req1 && (!req0 || !last_gnt_reg);

  assign push_data = {ser_out1, ser_out2, ser_out3, ser_out4};
  assign capture   = (state_reg == ST_WAIT) && (ser_move_cnt != last_cnt_reg) &&
                     (cap_cnt_reg < CAP_MAX);
  assign cap_full  = (cap_cnt_reg == CAP_MAX) || (capture && (cap_cnt_reg == CAP_LAST));
  assign wait_exit = ser_done && cap_full;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (grant) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_WAIT;
      ST_WAIT: if (wait_exit || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_load = 1'b0;
    busy     = 1'b1;
    case (state_reg)
      ST_IDLE: busy     = 1'b0;
      ST_LOAD: ser_load = 1'b1;
      default: ;
    endcase
  end

  // ---------------- grant / load datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      ser_in_reg   <= '0;
      last_gnt_reg <= 1'b1;
      last_cnt_reg <= '0;
      cap_cnt_reg  <= '0;
    end else begin
      gnt0_reg <= grant && !pick1;
      gnt1_reg <= grant && pick1;
      if (grant) begin
        ser_in_reg   <= pick1 ? data1 : data0;
        last_gnt_reg <= pick1;
      end
      if (state_reg == ST_LOAD) begin
        last_cnt_reg <= ser_move_cnt;
        cap_cnt_reg  <= '0;
      end else if (capture) begin
        last_cnt_reg <= ser_move_cnt;
        cap_cnt_reg  <= cap_cnt_reg + CAP_W'(1);
      end
    end
  end

  // ---------------- move FIFO ----------------
  assign push_ok     = capture && ((count_reg != CNT_FULL) || pop);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push_ok && pop) count_next = count_reg - CNT_W'(1);
  end

  // The new head comes from the incoming move only when it lands in the head slot.
  assign head_next = (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_data : mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      move_data_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) move_data_reg <= head_next;
      if (capture && !push_ok) overflow_reg <= 1'b1;
    end
  end

  // ---------------- optional WAIT watchdog ----------------
`ifdef SER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;

  assign timeout_hit = (state_reg == ST_WAIT) && !wait_exit &&
                       (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == ST_LOAD)      wd_cnt_reg <= '0;
      else if (state_reg == ST_WAIT) wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      if (timeout_hit) timeout_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  assign gnt0       = gnt0_reg;
  assign gnt1       = gnt1_reg;
  assign ser_in     = ser_in_reg;
  assign move_valid = (count_reg != '0);
  assign move_data  = move_data_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed self-checking bench for serializer_ctrl; the serializer is driven by hand from the bench.
`timescale 1ns/1ps
module tb_serializer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, ser_load;
  logic [31:0] ser_in;
  logic [3:0]  ser_out1 = '0, ser_out2 = '0, ser_out3 = '0, ser_out4 = '0;
  logic [3:0]  ser_move_cnt = '0;
  logic        ser_done = 1'b0;
  logic        move_valid;
  logic [15:0] move_data;
  logic        move_ready = 1'b0;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;
`ifdef SER_WATCHDOG_EN
  logic        timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  serializer_ctrl #(.MOVES_PER_WORD(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .ser_load(ser_load), .ser_in(ser_in),
    .ser_out1(ser_out1), .ser_out2(ser_out2), .ser_out3(ser_out3), .ser_out4(ser_out4),
    .ser_move_cnt(ser_move_cnt), .ser_done(ser_done),
    .move_valid(move_valid), .move_data(move_data), .move_ready(move_ready),
    .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
`ifdef SER_WATCHDOG_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check({tag, "_gnt0"}, 32'(gnt0), 32'h0);
    check({tag, "_gnt1"}, 32'(gnt1), 32'h0);
    check({tag, "_ser_load"}, 32'(ser_load), 32'h0);
    check({tag, "_ser_in"}, ser_in, 32'h0);
    check({tag, "_move_valid"}, 32'(move_valid), 32'h0);
    check({tag, "_move_data"}, 32'(move_data), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
`ifdef SER_WATCHDOG_EN
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
`endif
    reset = 1'b0;
  endtask

  // Wait (bounded) for the LOAD cycle; returns at the falling edge inside it.
  task automatic wait_load(input int max_cycles, input string tag);
    int n = 0;
    while (!ser_load && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_ser_load"}, 32'(ser_load), 32'h1);
    $display("load %s: gnt0=%0b gnt1=%0b ser_in=%h fifo_count=%0d", tag, gnt0, gnt1, ser_in, fifo_count);
  endtask

  // One serializer move: new nibbles plus counter step, optionally with done.
  task automatic emit(input logic [15:0] mv, input logic done);
    {ser_out1, ser_out2, ser_out3, ser_out4} = mv;
    ser_move_cnt = ser_move_cnt + 4'd1;
    ser_done = done;
    tick();
    ser_done = 1'b0;
    $display("move %h done=%0b: move_valid=%0b move_data=%h fifo_count=%0d", mv, done, move_valid, move_data, fifo_count);
  endtask

  logic [31:0] rr_word [3];
  logic [15:0] drain_exp [3];

  initial begin
    rr_word   = '{32'hAAAA0000, 32'h5555FFFF, 32'hAAAA0000};
    drain_exp = '{16'h1234, 16'h0F0F, 16'h7777};
    tick();

    // 1: single word from requester 0
    do_reset("t1_rst");
    data0 = 32'h12345670; req0 = 1'b1; move_ready = 1'b1;
    wait_load(8, "t1");
    check("t1_gnt0", 32'(gnt0), 32'h1);
    check("t1_gnt1", 32'(gnt1), 32'h0);
    check("t1_ser_in", ser_in, 32'h12345670);
    check("t1_busy_load", 32'(busy), 32'h1);
    req0 = 1'b0;
    tick();
    check("t1_gnt0_pulse", 32'(gnt0), 32'h0);
    check("t1_load_pulse", 32'(ser_load), 32'h0);
    emit(16'h1234, 1'b0);
    check("t1_valid0", 32'(move_valid), 32'h1);
    check("t1_move0", 32'(move_data), 32'h1234);
    emit(16'h5670, 1'b1);
    check("t1_move1", 32'(move_data), 32'h5670);
    check("t1_busy_end", 32'(busy), 32'h0);
    tick();
    check("t1_count_end", 32'(fifo_count), 32'h0);
    check("t1_valid_end", 32'(move_valid), 32'h0);
    check("t1_data_hold", 32'(move_data), 32'h5670);

    // 2: round-robin with both requesters always pending
    do_reset("t2_rst");
    data0 = 32'hAAAA0000; data1 = 32'h5555FFFF;
    req0 = 1'b1; req1 = 1'b1; move_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_load(8, $sformatf("t2_%0d", i));
      check($sformatf("t2_gnt0_%0d", i), 32'(gnt0), (i == 1) ? 32'h0 : 32'h1);
      check($sformatf("t2_gnt1_%0d", i), 32'(gnt1), (i == 1) ? 32'h1 : 32'h0);
      check($sformatf("t2_ser_in_%0d", i), ser_in, rr_word[i]);
      tick();
      emit(rr_word[i][31:16], 1'b0);
      emit(rr_word[i][15:0], 1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // 3: FIFO back-pressure holds off grants until two slots are free
    do_reset("t3_rst");
    move_ready = 1'b0;
    data0 = 32'h11112222; req0 = 1'b1;
    wait_load(8, "t3_a");
    data0 = 32'h33334444;
    tick();
    emit(16'h1111, 1'b0);
    emit(16'h2222, 1'b1);
    wait_load(8, "t3_b");
    check("t3_ser_in_b", ser_in, 32'h33334444);
    data0 = 32'h55556666;
    tick();
    emit(16'h3333, 1'b0);
    emit(16'h4444, 1'b1);
    check("t3_count_full", 32'(fifo_count), 32'h4);
    check("t3_head_first", 32'(move_data), 32'h1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t3_no_grant_full_%0d", i), {30'h0, gnt0, ser_load}, 32'h0);
    end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    check("t3_count_after_pop1", 32'(fifo_count), 32'h3);
    check("t3_head_after_pop1", 32'(move_data), 32'h2222);
    check("t3_no_grant_space1", {30'h0, gnt0, ser_load}, 32'h0);
    tick(); tick();
    check("t3_still_idle", {29'h0, busy, gnt0, ser_load}, 32'h0);
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    check("t3_grant_after_pop2", 32'(gnt0), 32'h1);
    check("t3_load_after_pop2", 32'(ser_load), 32'h1);
    check("t3_ser_in_c", ser_in, 32'h55556666);
    check("t3_count_after_pop2", 32'(fifo_count), 32'h2);
    check("t3_head_after_pop2", 32'(move_data), 32'h3333);
    req0 = 1'b0;
    tick();
    emit(16'h5555, 1'b0);
    emit(16'h6666, 1'b1);
    check("t3_count_refill", 32'(fifo_count), 32'h4);

    // 4: simultaneous push and pop at fifo_count=2
    do_reset("t4_rst");
    move_ready = 1'b0;
    data0 = 32'hABCD1234; req0 = 1'b1;
    wait_load(8, "t4_a");
    data0 = 32'h0F0F7777;
    tick();
    emit(16'hABCD, 1'b0);
    emit(16'h1234, 1'b1);
    wait_load(8, "t4_b");
    req0 = 1'b0;
    check("t4_count_pre", 32'(fifo_count), 32'h2);
    tick();
    move_ready = 1'b1;
    emit(16'h0F0F, 1'b0);
    move_ready = 1'b0;
    check("t4_count_pushpop", 32'(fifo_count), 32'h2);
    check("t4_head_pushpop", 32'(move_data), 32'h1234);
    emit(16'h7777, 1'b1);
    check("t4_count_post", 32'(fifo_count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_drain_valid_%0d", i), 32'(move_valid), 32'h1);
      check($sformatf("t4_drain_data_%0d", i), 32'(move_data), 32'(drain_exp[i]));
      move_ready = 1'b1;
      tick();
    end
    move_ready = 1'b0;
    check("t4_drained", 32'(fifo_count), 32'h0);

    // 5: reset in the middle of WAIT after one capture
    do_reset("t5_rst0");
    data0 = 32'hCAFEBEEF; req0 = 1'b1;
    wait_load(8, "t5_a");
    req0 = 1'b0;
    tick();
    emit(16'hCAFE, 1'b0);
    check("t5_count_one", 32'(fifo_count), 32'h1);
    check("t5_busy_wait", 32'(busy), 32'h1);
    do_reset("t5_rst_mid");
    data0 = 32'h13572468; req0 = 1'b1;
    wait_load(8, "t5_b");
    check("t5_gnt0_after", 32'(gnt0), 32'h1);
    check("t5_ser_in_after", ser_in, 32'h13572468);
    req0 = 1'b0;
    tick();
    emit(16'h1357, 1'b0);
    emit(16'h2468, 1'b1);
    check("t5_busy_done", 32'(busy), 32'h0);
    check("t5_count_done", 32'(fifo_count), 32'h2);

    // 6: serializer never signals done
    do_reset("t6_rst");
    data0 = 32'hDEAD0001; req0 = 1'b1;
    wait_load(8, "t6");
    req0 = 1'b0;
    tick();
    emit(16'hDEAD, 1'b0);
`ifdef SER_WATCHDOG_EN
    repeat (62) tick();
    check("t6_busy_before_timeout", 32'(busy), 32'h1);
    check("t6_no_timeout_yet", 32'(timeout_err), 32'h0);
    tick();
    check("t6_busy_after_timeout", 32'(busy), 32'h0);
    check("t6_timeout_err", 32'(timeout_err), 32'h1);
`else
    repeat (70) tick();
    check("t6_busy_stuck", 32'(busy), 32'h1);
`endif
    check("t6_count_kept", 32'(fifo_count), 32'h1);
    check("t6_head_kept", 32'(move_data), 32'hDEAD);
    check("t6_no_overflow", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
